// File: rtl/hazard_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_unit_pkg
// Description : Shared pipeline definitions for the ID-stage interlock logic.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_unit_pkg;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [4:0] ZERO_REG     = 5'd0;
    localparam int         PCSRC_JR_BIT = 1;

    // $zero is hardwired, so a write to it never produces a value to wait on.
    function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
        return (dst != ZERO_REG) && (dst == src);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_unit_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Event counter that sticks at all-ones instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] value
);

    logic [W-1:0] r_value;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_value <= '0;
        end else if (inc && (r_value != {W{1'b1}})) begin
            r_value <= r_value + 1'b1;
        end
    end

    assign value = r_value;

endmodule
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_unit
// Description : ID-stage interlock: load-use / branch-operand stalls, taken
//               branch squash and saturating stall/flush event counters.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_UsesRt,
    input  logic             ID_Branch,
    input  logic [1:0]       ID_PCSrc,
    input  logic             ID_Taken,
    input  logic             EX_MemRead,
    input  logic             EX_RegWrite,
    input  logic [4:0]       EX_WriteReg,
    input  logic             Ext_Stall,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic [CNT_W-1:0] Stall_Count,
    output logic [CNT_W-1:0] Flush_Count
);

    state_t r_state;
    state_t w_next_state;

    logic w_rs_br_use;
    logic w_rt_br_use;
    logic w_lu_match;
    logic w_br_match;
    logic w_hz_lu;
    logic w_hz_ba;
    logic w_hz_bl;
    logic w_stall;
    logic w_stall_inc;
    logic w_unused_pcsrc;

    // Only the jr/jalr bit of PCSrc matters for operand reads in ID.
    assign w_unused_pcsrc = ID_PCSrc[0];

    always_comb begin
        w_next_state = r_state;
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        w_stall_inc  = 1'b0;

        w_rs_br_use = ID_Branch | ID_PCSrc[PCSRC_JR_BIT];
        w_rt_br_use = ID_Branch;

        w_lu_match = reg_match(EX_WriteReg, ID_Rs)
                   | (ID_UsesRt & reg_match(EX_WriteReg, ID_Rt));
        w_br_match = (w_rs_br_use & reg_match(EX_WriteReg, ID_Rs))
                   | (w_rt_br_use & reg_match(EX_WriteReg, ID_Rt));

        w_hz_lu = EX_MemRead & w_lu_match;
        w_hz_ba = w_br_match & EX_RegWrite & ~EX_MemRead;
        w_hz_bl = w_br_match & EX_MemRead;

        w_stall = (r_state == HOLD) | w_hz_lu | w_hz_ba | w_hz_bl;

        if (reset) begin
            w_next_state = RUN;
        end else if (Ext_Stall) begin
            // Freeze: state held, so a pending HOLD survives the freeze.
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
        end else if (w_stall) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Flush  = 1'b1;
            w_stall_inc  = 1'b1;
            // A branch on a load needs one more cycle while the load is in MEM.
            w_next_state = ((r_state == RUN) && w_hz_bl) ? HOLD : RUN;
        end else if (ID_Taken) begin
            IF_ID_Flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_count (
        .clk   (clk),
        .reset (reset),
        .inc   (w_stall_inc),
        .value (Stall_Count)
    );

    sat_counter #(.W(CNT_W)) u_flush_count (
        .clk   (clk),
        .reset (reset),
        .inc   (IF_ID_Flush),
        .value (Flush_Count)
    );

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_unit
// Description : Directed and random checks of hazard_unit against a
//               rule-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_unit;

    localparam int CNT_W   = 16;
    localparam int CNT_MAX = 65535;

    logic             clk;
    logic             reset;
    logic [4:0]       ID_Rs, ID_Rt;
    logic             ID_UsesRt, ID_Branch, ID_Taken;
    logic [1:0]       ID_PCSrc;
    logic             EX_MemRead, EX_RegWrite;
    logic [4:0]       EX_WriteReg;
    logic             Ext_Stall;
    logic             PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush;
    logic [CNT_W-1:0] Stall_Count, Flush_Count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit m_hold;
    int m_stall_cnt;
    int m_flush_cnt;

    hazard_unit #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .ID_Rs       (ID_Rs),
        .ID_Rt       (ID_Rt),
        .ID_UsesRt   (ID_UsesRt),
        .ID_Branch   (ID_Branch),
        .ID_PCSrc    (ID_PCSrc),
        .ID_Taken    (ID_Taken),
        .EX_MemRead  (EX_MemRead),
        .EX_RegWrite (EX_RegWrite),
        .EX_WriteReg (EX_WriteReg),
        .Ext_Stall   (Ext_Stall),
        .PC_Write    (PC_Write),
        .IF_ID_Write (IF_ID_Write),
        .IF_ID_Flush (IF_ID_Flush),
        .ID_EX_Flush (ID_EX_Flush),
        .Stall_Count (Stall_Count),
        .Flush_Count (Flush_Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        reset       = 1'b0;
        ID_Rs       = 5'd0;
        ID_Rt       = 5'd0;
        ID_UsesRt   = 1'b0;
        ID_Branch   = 1'b0;
        ID_PCSrc    = 2'b00;
        ID_Taken    = 1'b0;
        EX_MemRead  = 1'b0;
        EX_RegWrite = 1'b0;
        EX_WriteReg = 5'd0;
        Ext_Stall   = 1'b0;
    endtask

    task automatic clear_ex();
        EX_MemRead  = 1'b0;
        EX_RegWrite = 1'b0;
        EX_WriteReg = 5'd0;
    endtask

    // One clock: predict from the current inputs, compare, clock, advance model.
    task automatic cycle(input bit check_ctl = 1'b1);
        int  lu_reads[$];
        int  br_reads[$];
        bit  produces, lu, br_dep, br_alu, br_load, stall, flush;
        logic [3:0] exp_ctl;

        lu_reads.push_back(int'(ID_Rs));
        if (ID_UsesRt) lu_reads.push_back(int'(ID_Rt));
        if (ID_Branch || ID_PCSrc[1]) br_reads.push_back(int'(ID_Rs));
        if (ID_Branch) br_reads.push_back(int'(ID_Rt));

        produces = (EX_WriteReg != 5'd0);
        lu = 1'b0;
        br_dep = 1'b0;
        foreach (lu_reads[i]) if (produces && lu_reads[i] == int'(EX_WriteReg)) lu = 1'b1;
        foreach (br_reads[i]) if (produces && br_reads[i] == int'(EX_WriteReg)) br_dep = 1'b1;
        lu      = lu && EX_MemRead;
        br_load = br_dep && EX_MemRead;
        br_alu  = br_dep && EX_RegWrite && !EX_MemRead;
        stall   = m_hold || lu || br_alu || br_load;
        flush   = !stall && ID_Taken;

        // {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush}
        if (reset)          exp_ctl = 4'b1100;
        else if (Ext_Stall) exp_ctl = 4'b0000;
        else if (stall)     exp_ctl = 4'b0001;
        else if (flush)     exp_ctl = 4'b1110;
        else                exp_ctl = 4'b1100;

        #2;
        if (check_ctl) begin
            check("ctl", {28'd0, PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush}, {28'd0, exp_ctl});
            check("stall_cnt", {16'd0, Stall_Count}, m_stall_cnt);
            check("flush_cnt", {16'd0, Flush_Count}, m_flush_cnt);
        end

        @(posedge clk);
        #1;
        if (reset) begin
            m_hold      = 1'b0;
            m_stall_cnt = 0;
            m_flush_cnt = 0;
        end else if (!Ext_Stall) begin
            if (stall && m_stall_cnt < CNT_MAX) m_stall_cnt++;
            if (flush && m_flush_cnt < CNT_MAX) m_flush_cnt++;
            m_hold = m_hold ? 1'b0 : br_load;
        end
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        m_hold = 1'b0;
        m_stall_cnt = 0;
        m_flush_cnt = 0;

        // Reset dominates a live hazard and a freeze request
        ID_Rs = 5'd8; EX_MemRead = 1'b1; EX_WriteReg = 5'd8; Ext_Stall = 1'b1;
        cycle();
        check("reset_stall_cnt", {16'd0, Stall_Count}, 32'd0);

        // Load-use on Rs
        do_reset();
        EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_WriteReg = 5'd8; ID_Rs = 5'd8;
        cycle();
        clear_ex();
        cycle();
        check("lu_stall_cnt", {16'd0, Stall_Count}, 32'd1);

        // Branch on ALU result
        do_reset();
        EX_RegWrite = 1'b1; EX_WriteReg = 5'd9; ID_Branch = 1'b1; ID_Rt = 5'd9; ID_Rs = 5'd3;
        cycle();
        clear_ex();
        cycle();
        cycle();
        check("ba_stall_cnt", {16'd0, Stall_Count}, 32'd1);

        // jr on load result: two stalls then squash
        do_reset();
        EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_WriteReg = 5'd9;
        ID_Rs = 5'd9; ID_PCSrc = 2'b10; ID_Taken = 1'b1;
        cycle();
        clear_ex();
        cycle();
        cycle();
        ID_Taken = 1'b0; ID_PCSrc = 2'b00;
        cycle();
        check("bl_stall_cnt", {16'd0, Stall_Count}, 32'd2);
        check("bl_flush_cnt", {16'd0, Flush_Count}, 32'd1);

        // Stall beats a taken branch
        do_reset();
        EX_RegWrite = 1'b1; EX_WriteReg = 5'd9; ID_Branch = 1'b1; ID_Rt = 5'd9; ID_Taken = 1'b1;
        cycle();
        clear_ex();
        cycle();
        check("prio_flush_cnt", {16'd0, Flush_Count}, 32'd1);

        // Freeze in the middle of HOLD
        do_reset();
        EX_MemRead = 1'b1; EX_WriteReg = 5'd9; ID_Branch = 1'b1; ID_Rs = 5'd9;
        cycle();
        clear_ex();
        Ext_Stall = 1'b1;
        repeat (3) cycle();
        Ext_Stall = 1'b0;
        cycle();
        cycle();
        check("freeze_stall_cnt", {16'd0, Stall_Count}, 32'd2);

        // Reset while in HOLD drops the pending stall
        do_reset();
        EX_MemRead = 1'b1; EX_WriteReg = 5'd9; ID_Branch = 1'b1; ID_Rs = 5'd9;
        cycle();
        clear_ex();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();
        check("rst_hold_stall_cnt", {16'd0, Stall_Count}, 32'd0);

        // $zero destination never stalls
        do_reset();
        EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_WriteReg = 5'd0;
        ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRt = 1'b1; ID_Branch = 1'b1;
        cycle();
        check("zero_reg_stall_cnt", {16'd0, Stall_Count}, 32'd0);

        // Random traffic over a small register set so hazards are frequent
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            reset       = ($urandom_range(0, 49) == 0);
            Ext_Stall   = ($urandom_range(0, 7) == 0);
            ID_Rs       = 5'($urandom_range(0, 3));
            ID_Rt       = 5'($urandom_range(0, 3));
            ID_UsesRt   = 1'($urandom);
            ID_Branch   = ($urandom_range(0, 2) == 0);
            ID_PCSrc    = 2'($urandom);
            ID_Taken    = 1'($urandom);
            EX_MemRead  = 1'($urandom);
            EX_RegWrite = 1'($urandom);
            EX_WriteReg = 5'($urandom_range(0, 3));
            cycle();
        end

        // Saturation of the stall counter under a permanent load-use
        do_reset();
        EX_MemRead = 1'b1; EX_WriteReg = 5'd8; ID_Rs = 5'd8;
        for (int n = 0; n < 70000; n++) begin
            cycle((n % 64 == 0) || (n > 65500));
        end
        check("sat_stall_cnt", {16'd0, Stall_Count}, 32'h0000FFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_unit.md
# hazard_unit

Pipeline interlock controller sitting in ID, alongside the forwarding unit. It detects hazards that forwarding cannot cover (load-use, and a branch or jr whose operand is still being produced in EX) and stalls IF/ID while injecting bubbles into ID/EX. It squashes the fetched instruction after a taken branch or jump, and it keeps saturating stall/flush event counters for performance debug.

## Interface
- CNT_W, 16, width of each event counter
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high
- ID_Rs, ID_Rt  in  5 each  source register numbers of the instruction in ID
- ID_UsesRt  in  1  ID instruction reads Rt as an operand
- ID_Branch  in  1  ID instruction is a conditional branch (compares Rs, Rt in ID)
- ID_PCSrc  in  2  PC source of the ID instruction; bit 1 = jr/jalr (reads Rs in ID)
- ID_Taken  in  1  ID redirects the PC (taken branch, j, jal, jr)
- EX_MemRead  in  1  EX instruction is a load
- EX_RegWrite  in  1  EX instruction writes a register
- EX_WriteReg  in  5  destination of the EX instruction
- Ext_Stall  in  1  global freeze request (memory not ready)
- PC_Write  out  1  PC load enable
- IF_ID_Write  out  1  IF/ID load enable
- IF_ID_Flush  out  1  zero IF/ID on the next edge
- ID_EX_Flush  out  1  load a bubble (all control zero) into ID/EX
- Stall_Count  out  CNT_W  hazard stall cycles, saturating
- Flush_Count  out  CNT_W  IF/ID squashes, saturating

## Operation
- Reads in ID: RsUse = ID_Branch | ID_PCSrc[1] for the branch checks; RtUse = ID_Branch.
- For the load-use check, Rs is always treated as used, and Rt is used when ID_UsesRt = 1.
- A match requires EX_WriteReg != 0 and EX_WriteReg equal to the used source.
- Hazard classes, evaluated in state RUN:
  - LU (load-use): EX_MemRead & match (Rs, or Rt when ID_UsesRt). Stall 1 cycle.
  - BA (branch on ALU result): branch-read match & EX_RegWrite & !EX_MemRead. Stall 1 cycle. The result is then forwarded from MEM.
  - BL (branch on load): branch-read match & EX_MemRead. Stall 2 cycles.
- FSM states:
  - RUN. BL moves to HOLD. Any other condition stays in RUN.
  - HOLD. Stall is forced regardless of inputs, then the FSM returns to RUN. This covers the cycle in which the load sits in MEM, where the data is not yet forwardable.
- Stall asserted (hazard in RUN, or state HOLD): PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1, IF_ID_Flush=0.
- Stall has priority over ID_Taken, because the branch outcome is not valid while stalled.
- No stall and ID_Taken=1: IF_ID_Flush=1, PC_Write=1, IF_ID_Write=1, ID_EX_Flush=0.
- Otherwise: PC_Write=1, IF_ID_Write=1, both flushes 0.
- Ext_Stall=1 overrides everything:
  - Outputs: PC_Write=0, IF_ID_Write=0, both flushes 0.
  - FSM state and counters hold.
  - A pending HOLD is preserved and re-evaluated after the freeze.
- Counters:
  - Stall_Count increments on every non-frozen stall cycle, including HOLD.
  - Flush_Count increments on every IF_ID_Flush=1 cycle.
  - Both saturate at all-ones.

## Timing
- Control outputs are combinational (Mealy) from the current state and inputs. They are valid before the same clk edge that updates the pipeline registers.
- State and counters update on the rising edge of clk.
- Stall lengths: LU 1 cycle, BA 1 cycle, BL 2 consecutive cycles. The instruction in ID is the same throughout the stall.
- A counter increment is visible the cycle after the event.
- reset=1:
  - On the edge: state becomes RUN and both counters become 0.
  - While reset is high, outputs are PC_Write=1, IF_ID_Write=1, both flushes 0, independent of the other inputs.
- reset asserted while in HOLD: the next state is RUN and no extra stall cycle occurs.
- EX_WriteReg=0 never causes a stall, even with EX_MemRead=1.

## Structure
- Shared pipeline package holds:
  - state encoding: RUN=1'b0, HOLD=1'b1
  - ZERO_REG = 5'd0
  - the PCSrc bit index for jr (1)
- Sub-module sat_counter (parameter W; ports clk, reset, inc, value), instantiated twice.
- The rest is a single always block for next-state and output logic plus the state register.

## Test plan
- LU: EX lw writes $8 (EX_MemRead=1, EX_WriteReg=8); ID add reads Rs=8 -> one cycle with PC_Write=0, ID_EX_Flush=1, then normal; Stall_Count 0→1.
- BA: EX add writes $9; ID beq with Rt=9 -> exactly one stall cycle and no HOLD entry.
- BL: EX lw writes $9; ID jr with Rs=9 (ID_PCSrc=2'b10) -> two stall cycles, the second with EX inputs at 0, then the flush when ID_Taken=1; Stall_Count=2, Flush_Count=1.
- Priority: BA hazard with ID_Taken=1 in the same cycle -> IF_ID_Flush=0 and stall asserted; next cycle with no hazard -> IF_ID_Flush=1.
- Freeze and reset: BL with Ext_Stall=1 for 3 cycles mid-HOLD -> outputs frozen, counters unchanged, HOLD stall still occurs after release. Separately, reset in HOLD -> RUN, counters 0, no stall.
- Edge cases: EX_WriteReg=0 with EX_MemRead=1 and Rs=0 -> no stall. 70000 forced stall cycles -> Stall_Count holds at 16'hFFFF.
